// File: rtl/ltsm_sb_tx_arbiter.sv
// ltsm_sb_tx_arbiter
// Round-robin arbiter that shares the single sideband TX message path among
// the LTSM sub-state handshake blocks. The arbiter grants one requester,
// latches its message and holds o_sb_valid until the SB encoder finishes
// serialising the message (falling edge of i_sb_busy). It then returns a
// one-cycle done pulse to that requester. A wait timeout and a flush input
// keep a stuck or abandoned transfer from locking the sideband.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_flush      LTSM state change; aborts any transfer, blocks new grants
//   i_req_valid  per-requester request level
//   i_req_msg    per-requester message, requester k at [k*SB_MSG_WIDTH +: SB_MSG_WIDTH]
//   i_sb_busy    SB is serialising the current message
//   o_sb_valid   message valid to SB encoder
//   o_sb_msg     latched message to SB encoder
//   o_grant      one-hot current owner, 0 when idle
//   o_req_done   one-cycle completion pulse to the owner
//   o_timeout    one-cycle pulse when a grant times out waiting for busy
module ltsm_sb_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg,
    input  logic                            i_sb_busy,
    output logic                            o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0]         o_sb_msg,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_req_done,
    output logic                            o_timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic                r_busy_q;
    logic                r_busy_seen;
    logic [TMR_W-1:0]    r_timer;

    logic                w_fall;
    logic                w_found;
    logic [PTR_W-1:0]    w_sel;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_owner_next;
    logic [SB_MSG_WIDTH-1:0] w_sel_msg;

    assign w_fall       = r_busy_q & ~i_sb_busy;
    assign w_owner_next = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_sel_msg    = i_req_msg[w_sel*SB_MSG_WIDTH +: SB_MSG_WIDTH];

    // First requesting index at or above r_rr_ptr, wrapping modulo NUM_REQ.
    // The wrap is a compare-and-subtract so NUM_REQ need not be a power of two.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_busy_q    <= 1'b0;
            r_busy_seen <= 1'b0;
            r_timer     <= '0;
            o_sb_valid  <= 1'b0;
            o_sb_msg    <= '0;
            o_grant     <= '0;
            o_req_done  <= '0;
            o_timeout   <= 1'b0;
        end else begin
            r_busy_q   <= i_sb_busy;
            o_req_done <= '0;
            o_timeout  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!i_flush && w_found) begin
                        r_state     <= ST_SEND;
                        r_owner     <= w_sel;
                        o_grant     <= NUM_REQ'(1) << w_sel;
                        o_sb_msg    <= w_sel_msg;
                        o_sb_valid  <= 1'b1;
                        r_timer     <= '0;
                        r_busy_seen <= 1'b0;
                    end
                end

                ST_SEND: begin
                    if (i_flush) begin
                        r_state    <= ST_GAP;
                        o_sb_valid <= 1'b0;
                        o_grant    <= '0;
                    end else if (w_fall && r_busy_seen) begin
                        r_state    <= ST_GAP;
                        o_sb_valid <= 1'b0;
                        o_grant    <= '0;
                        o_req_done <= NUM_REQ'(1) << r_owner;
                        r_rr_ptr   <= w_owner_next;
                    end else if (!r_busy_seen && !i_req_valid[r_owner]) begin
                        // Withdrawn before the SB accepted it: no credit, pointer kept.
                        r_state    <= ST_GAP;
                        o_sb_valid <= 1'b0;
                        o_grant    <= '0;
                    end else if (!r_busy_seen && (r_timer == TMR_MAX)) begin
                        r_state    <= ST_GAP;
                        o_sb_valid <= 1'b0;
                        o_grant    <= '0;
                        o_timeout  <= 1'b1;
                        r_rr_ptr   <= w_owner_next;
                    end else if (!r_busy_seen) begin
                        // A level check also covers busy already high on SEND entry.
                        r_busy_seen <= i_sb_busy;
                        r_timer     <= r_timer + 1'b1;
                    end
                end

                ST_GAP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ltsm_sb_tx_arbiter.md
Name: ltsm_sb_tx_arbiter

Overview:
Round-robin arbiter that shares the single sideband TX message path among the LTSM sub-state handshake blocks (TRAINERROR, and the TX/RX handshake blocks of the other sub-states).
- Each requester presents a valid flag and an encoded SB message. The arbiter grants one requester at a time and drives the encoded message and valid to the SB encoder.
- It holds the message until the SB finishes serialising it, signalled by a falling edge of busy, then returns a per-requester done pulse.
- It adds a timeout and a flush so a stuck or abandoned transfer cannot lock the sideband.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SB_MSG_WIDTH, 4, width of encoded SB message
TIMEOUT_CYCLES, 255, max cycles to wait for i_sb_busy to rise after valid is driven; counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_flush  input  1  LTSM state change; aborts any transfer
i_req_valid  input  NUM_REQ  per-requester request, level
i_req_msg  input  NUM_REQ*SB_MSG_WIDTH  per-requester message; requester k uses bits [k*SB_MSG_WIDTH +: SB_MSG_WIDTH]
i_sb_busy  input  1  SB serialising current message
o_sb_valid  output  1  message valid to SB encoder
o_sb_msg  output  SB_MSG_WIDTH  encoded message to SB
o_grant  output  NUM_REQ  one-hot current owner, 0 when idle
o_req_done  output  NUM_REQ  one-cycle pulse to owner on completion
o_timeout  output  1  one-cycle pulse when a grant times out

Behaviour:
- All outputs registered. Reset values: o_sb_valid=0, o_sb_msg=0, o_grant=0, o_req_done=0, o_timeout=0. Internal state: rr_ptr=0, busy_q=0, busy_seen=0, timer=0, state=IDLE.
- busy_q is i_sb_busy delayed one cycle.
  - fall = busy_q & ~i_sb_busy
  - rise = ~busy_q & i_sb_busy
- States: IDLE, SEND, GAP.
- IDLE:
  - If any i_req_valid is set and i_flush=0, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next cycle: state=SEND, o_grant=onehot(k), o_sb_msg=the msg slice of k (latched), o_sb_valid=1, timer=0, busy_seen=0.
  - Latency from request to o_sb_valid is 1 cycle.
- SEND, evaluated in priority order:
  1. i_flush: next cycle o_sb_valid=0, o_grant=0, no done pulse; go to GAP.
  2. fall with busy_seen=1: o_req_done[k]=1 for one cycle, o_sb_valid=0, o_grant=0, rr_ptr=(k+1) mod NUM_REQ; go to GAP.
  3. busy_seen=0 and i_req_valid[k]=0 (requester withdrew before SB accepted): abort, same as flush, rr_ptr unchanged.
  4. busy_seen=0 and timer==TIMEOUT_CYCLES: o_timeout=1 pulse, drop valid and grant, rr_ptr=(k+1) mod NUM_REQ; go to GAP.
  5. Otherwise stay in SEND. Set busy_seen on rise or when i_sb_busy=1; increment timer while busy_seen=0.
- After busy_seen=1, requester withdrawal is ignored and the transfer completes on fall.
- o_sb_msg is latched and stable for the entire SEND. A change on i_req_msg during SEND has no effect.
- GAP: exactly one cycle with o_sb_valid=0, then IDLE. This guarantees the SB sees a valid deassertion between back-to-back messages.
- A fall seen in IDLE or GAP is ignored.
- i_flush in IDLE or GAP blocks a new grant that cycle.
- Simultaneous rise and fall cannot occur, since busy_q is a single bit.
- If i_sb_busy is already high on SEND entry, busy_seen is set on the first SEND cycle.
- Asynchronous reset mid-transfer returns to reset values immediately; no done pulse.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transfers.

Test Plan:
1. Single request: req_valid=4'b0100, msg2=4'hF; busy 0→1 at cycle 3, 1→0 at cycle 6 -> o_sb_valid=1 and o_sb_msg=F from cycle 1; o_req_done=4'b0100 pulses one cycle after the fall; o_sb_valid=0 with one GAP cycle.
2. Round-robin: all four requesting continuously, each transfer completed by a busy pulse -> grant order 0,1,2,3,0; at least one valid-low cycle between messages.
3. Withdrawal before accept: grant to req1, drop req_valid[1] before busy rises -> valid drops next cycle, no done, rr_ptr stays 1, req1 regranted when it re-requests.
4. Timeout: TIMEOUT_CYCLES=8, busy held 0 -> o_timeout pulses after 8 wait cycles, grant released, next requester served.
5. Flush mid-SEND with busy=1 -> o_sb_valid=0 and o_grant=0 next cycle, no o_req_done, later fall ignored.
6. Reset asserted during SEND with busy=1 -> all outputs 0 asynchronously; after release, first grant goes to req0 when all request.
